pkt_rx_ctrl: RTL and testbench
==============================

Name: pkt_rx_ctrl

Overview:
Receive-side controller for the serial packet link. Hunts the 1-bit-per-cycle stream for an 8-bit header, then reads an 8-bit length field. It then deserializes that many payload bytes, MSB first, and presents each byte on a valid/ready byte interface. It sits between the serial line sampler and the byte-wide packet consumer, and reports framing events (header seen, length error, overrun, packet done).

Parameters:
HEADER, 8'hB6, header pattern, MSB first
MAX_LEN, 16, largest legal length field (1..255); larger values are rejected

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  qualifies in_bit; no state advances when low
in_bit  input  1  serial data bit, MSB first
out_data  output  8  payload byte
out_valid  output  1  out_data holds an unconsumed byte
out_ready  input  1  consumer accepts byte when out_valid & out_ready
out_last  output  1  out_data is final byte of packet (qualified by out_valid)
hdr_seen  output  1  one-cycle pulse: header matched
len_err  output  1  one-cycle pulse: length > MAX_LEN, packet dropped
overrun  output  1  one-cycle pulse: payload byte lost because holding register was full
pkt_done  output  1  one-cycle pulse: packet framing complete, back to HUNT
busy  output  1  high in LEN and PAYLOAD states

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset forces:
  - state=HUNT; shift register, bit counter, hunt fill counter, remaining-byte counter = 0
  - out_data=0; out_valid, out_last, hdr_seen, len_err, overrun, pkt_done, busy = 0
- Reset mid-packet discards everything, including a held byte.
- All outputs are registered. Every pulse appears the cycle after the clock edge that sampled the triggering bit.
- A "bit" is a cycle with in_valid=1. Cycles with in_valid=0 change nothing except the output handshake.

HUNT state:
- Shift: sreg <= {sreg[6:0], in_bit}.
- Fill counter saturates at 8. A match requires fill >= 7 before the shift, so HEADER=8'h00 cannot match on reset zeros.
- Match condition: {sreg[6:0], in_bit} == HEADER. Overlapping headers are found, with no dead cycles.
- On match: hdr_seen pulse; go to LEN; bit counter=0.

LEN state:
- Collect 8 bits MSB first. On the 8th bit, let L be the assembled value.
  - L == 0: pkt_done pulse, go to HUNT.
  - L > MAX_LEN: len_err pulse, go to HUNT.
  - Otherwise: remaining = L, go to PAYLOAD.

PAYLOAD state:
- Collect 8 bits per byte. On the 8th bit:
  - If the holding register is free, load out_data, set out_valid=1, and set out_last=(remaining==1).
  - The register counts as free when out_valid=0, or when out_valid & out_ready in the same cycle.
  - Otherwise drop the byte and pulse overrun.
  - Either way, remaining decrements.
  - When remaining reaches 0: pkt_done pulse, go to HUNT. Do not wait for the consumer to drain the last byte.

Entering HUNT:
- Clears the fill counter and sreg. Payload bits never form a header.

Handshake:
- out_valid falls the cycle after out_valid & out_ready, unless a new byte loads that same cycle; in that case it stays high with new data.
- out_data and out_last are stable while out_valid=1 and out_ready=0.
- The consumer may hold out_ready low indefinitely. Bit reception continues, and losses are flagged via overrun.

Test Plan:
- Header after noise: stream 0x5A, 0xB6, 0x02, 0x3C, 0xC3 with out_ready=1 -> hdr_seen pulses once after the 16th bit; bytes 0x3C then 0xC3 appear with out_last on 0xC3; pkt_done pulses once.
- Overlap: stream bits 1011011_0110110 (0xB6 overlapping into a second 0xB6 start) -> hdr_seen fires at the first completion only; the following bits are parsed as the length field.
- Length rejects: header then 0x00 -> pkt_done, no out_valid. Header then 0x11 with MAX_LEN=16 -> len_err, busy drops, and the next header is detected.
- Backpressure: header, 0x03, payload 0x11, 0x22, 0x33, out_ready=0 throughout -> out_data holds 0x11; overrun pulses twice; pkt_done pulses.
- Gapped input: same packet as the first scenario with in_valid toggling 1,0,0,1... -> identical byte sequence and pulses, each delayed by the gaps.
- Async reset mid-PAYLOAD with out_valid=1 -> all outputs 0 immediately, without waiting for a clock; the next full header-plus-packet is received correctly.

Source files
------------

// File: rtl/pkt_rx_ctrl.sv
// Serial packet receiver: hunts for a header byte, reads a length byte, then deserializes
// the payload MSB first onto a single-entry valid/ready byte interface with framing pulses.
module pkt_rx_ctrl #(
    parameter logic [7:0]  HEADER  = 8'hB6,
    parameter int unsigned MAX_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       hdr_seen,
    output logic       len_err,
    output logic       overrun,
    output logic       pkt_done,
    output logic       busy
);

    typedef enum logic [1:0] {StHunt, StLen, StPayload} state_e;

    state_e     state_q, state_d;
    logic [7:0] sreg_q, sreg_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] fill_q, fill_d;
    logic [7:0] rem_q, rem_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       out_last_q, out_last_d;
    logic       hdr_seen_q, hdr_seen_d;
    logic       len_err_q, len_err_d;
    logic       overrun_q, overrun_d;
    logic       pkt_done_q, pkt_done_d;
    logic       busy_q, busy_d;

    logic [7:0] shifted;
    logic       byte_done;
    logic       holding_free;
    logic       enter_hunt;

    assign shifted      = {sreg_q[6:0], in_bit};
    assign byte_done    = (bit_cnt_q == 3'd7);
    // The held byte may be replaced in the same cycle the consumer takes it.
    assign holding_free = !out_valid_q || out_ready;

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        bit_cnt_d   = bit_cnt_q;
        fill_d      = fill_q;
        rem_d       = rem_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        hdr_seen_d  = 1'b0;
        len_err_d   = 1'b0;
        overrun_d   = 1'b0;
        pkt_done_d  = 1'b0;
        enter_hunt  = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (in_valid) begin
            unique case (state_q)
                StHunt: begin
                    sreg_d = shifted;
                    if (fill_q != 4'd8) begin
                        fill_d = fill_q + 4'd1;
                    end
                    // Require seven real bits already shifted in, so reset zeros never match.
                    if (fill_q >= 4'd7 && shifted == HEADER) begin
                        hdr_seen_d = 1'b1;
                        state_d    = StLen;
                        bit_cnt_d  = 3'd0;
                        sreg_d     = 8'd0;
                    end
                end
                StLen: begin
                    sreg_d    = shifted;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (byte_done) begin
                        if (shifted == 8'd0) begin
                            pkt_done_d = 1'b1;
                            enter_hunt = 1'b1;
                        end else if (32'(shifted) > MAX_LEN) begin
                            len_err_d  = 1'b1;
                            enter_hunt = 1'b1;
                        end else begin
                            rem_d   = shifted;
                            state_d = StPayload;
                        end
                    end
                end
                StPayload: begin
                    sreg_d    = shifted;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (byte_done) begin
                        if (holding_free) begin
                            out_data_d  = shifted;
                            out_valid_d = 1'b1;
                            out_last_d  = (rem_q == 8'd1);
                        end else begin
                            overrun_d = 1'b1;
                        end
                        rem_d = rem_q - 8'd1;
                        if (rem_q == 8'd1) begin
                            pkt_done_d = 1'b1;
                            enter_hunt = 1'b1;
                        end
                    end
                end
                default: begin
                    enter_hunt = 1'b1;
                end
            endcase
        end

        // Clearing the hunt window keeps payload bits from forming a header.
        if (enter_hunt) begin
            state_d   = StHunt;
            sreg_d    = 8'd0;
            fill_d    = 4'd0;
            bit_cnt_d = 3'd0;
        end

        busy_d = (state_d != StHunt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StHunt;
            sreg_q      <= 8'd0;
            bit_cnt_q   <= 3'd0;
            fill_q      <= 4'd0;
            rem_q       <= 8'd0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            hdr_seen_q  <= 1'b0;
            len_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
            pkt_done_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            bit_cnt_q   <= bit_cnt_d;
            fill_q      <= fill_d;
            rem_q       <= rem_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            hdr_seen_q  <= hdr_seen_d;
            len_err_q   <= len_err_d;
            overrun_q   <= overrun_d;
            pkt_done_q  <= pkt_done_d;
            busy_q      <= busy_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign hdr_seen  = hdr_seen_q;
    assign len_err   = len_err_q;
    assign overrun   = overrun_q;
    assign pkt_done  = pkt_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pkt_rx_ctrl.sv
// Bench for pkt_rx_ctrl: table-driven packet scenarios, an async-reset sequence and random
// traffic, all cycle-checked against a bit-stream reference model.
module tb_pkt_rx_ctrl;

    localparam logic [7:0] HDR  = 8'hB6;
    localparam int         MAXL = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_bit, out_ready;
    logic [7:0] out_data;
    logic       out_valid, out_last, hdr_seen, len_err, overrun, pkt_done, busy;

    always #5 clk = ~clk;

    pkt_rx_ctrl #(
        .HEADER  (HDR),
        .MAX_LEN (MAXL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .hdr_seen  (hdr_seen),
        .len_err   (len_err),
        .overrun   (overrun),
        .pkt_done  (pkt_done),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: phase 0 hunts, 1 reads length, 2 reads payload.
    int         m_phase, m_hist, m_nhist, m_acc, m_nb, m_left;
    logic [7:0] e_data;
    logic       e_valid, e_last, e_hdr, e_lerr, e_ovr, e_done, e_busy;

    task automatic model_hunt();
        m_phase = 0; m_hist = 0; m_nhist = 0; m_acc = 0; m_nb = 0;
    endtask

    task automatic model_reset();
        model_hunt();
        m_left = 0; e_data = 8'h00;
        e_valid = 0; e_last = 0; e_hdr = 0; e_lerr = 0; e_ovr = 0; e_done = 0; e_busy = 0;
    endtask

    task automatic model_step(input logic vld, input logic b, input logic rdy);
        e_hdr = 0; e_lerr = 0; e_ovr = 0; e_done = 0;
        if (e_valid && rdy) e_valid = 0;
        if (vld) begin
            case (m_phase)
                0: begin
                    m_hist = (m_hist * 2 + int'(b)) % 256;
                    if (m_nhist < 8) m_nhist++;
                    if (m_nhist == 8 && m_hist == int'(HDR)) begin
                        e_hdr = 1; m_phase = 1; m_acc = 0; m_nb = 0;
                    end
                end
                1: begin
                    m_acc = m_acc * 2 + int'(b); m_nb++;
                    if (m_nb == 8) begin
                        if (m_acc == 0) begin
                            e_done = 1; model_hunt();
                        end else if (m_acc > MAXL) begin
                            e_lerr = 1; model_hunt();
                        end else begin
                            m_left = m_acc; m_phase = 2; m_acc = 0; m_nb = 0;
                        end
                    end
                end
                default: begin
                    m_acc = m_acc * 2 + int'(b); m_nb++;
                    if (m_nb == 8) begin
                        if (!e_valid) begin
                            e_valid = 1; e_data = 8'(m_acc); e_last = (m_left == 1);
                        end else begin
                            e_ovr = 1;
                        end
                        m_left--; m_acc = 0; m_nb = 0;
                        if (m_left == 0) begin
                            e_done = 1; model_hunt();
                        end
                    end
                end
            endcase
        end
        e_busy = (m_phase != 0);
    endtask

    int         n_hdr, n_done, n_lerr, n_ovr;
    logic [7:0] got_data[$];
    logic       got_last[$];

    task automatic clear_counts();
        n_hdr = 0; n_done = 0; n_lerr = 0; n_ovr = 0;
        got_data.delete(); got_last.delete();
    endtask

    task automatic cycle(input logic vld, input logic b, input logic rdy);
        in_valid = vld; in_bit = b; out_ready = rdy;
        if (out_valid && rdy) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
        end
        @(posedge clk);
        model_step(vld, b, rdy);
        #1;
        check("cycle", 32'({out_data, out_valid, out_last, hdr_seen, len_err, overrun,
                            pkt_done, busy}),
                       32'({e_data, e_valid, e_last, e_hdr, e_lerr, e_ovr, e_done, e_busy}));
        n_hdr  += int'(hdr_seen);
        n_done += int'(pkt_done);
        n_lerr += int'(len_err);
        n_ovr  += int'(overrun);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic rdy, input int gap);
        for (int k = 7; k >= 0; k--) begin
            cycle(1'b1, b[k], rdy);
            for (int g = 0; g < gap; g++) cycle(1'b0, 1'($urandom_range(0, 1)), rdy);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
    endtask

    typedef struct {
        string       name;
        logic [63:0] bytes;     // byte i at [63-8*i -: 8]
        int          nbytes;
        logic        rdy;
        int          gap;
        int          e_hdr, e_done, e_lerr, e_ovr, e_nout;
        logic [31:0] e_out;     // expected byte i at [31-8*i -: 8]
        logic [3:0]  e_lastmask;
        logic        hold_chk;
        logic [7:0]  hold_val;
    } vec_t;

    vec_t tv[6];

    task automatic run_vec(input vec_t v);
        clear_counts();
        for (int i = 0; i < v.nbytes; i++) send_byte(v.bytes[63-8*i -: 8], v.rdy, v.gap);
        if (v.hold_chk) begin
            check({v.name, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({v.name, "_hold_data"}, 32'(out_data), 32'(v.hold_val));
        end
        drain();
        check({v.name, "_hdr"},  n_hdr,  v.e_hdr);
        check({v.name, "_done"}, n_done, v.e_done);
        check({v.name, "_lerr"}, n_lerr, v.e_lerr);
        check({v.name, "_ovr"},  n_ovr,  v.e_ovr);
        check({v.name, "_nout"}, got_data.size(), v.e_nout);
        for (int i = 0; i < v.e_nout && i < got_data.size(); i++) begin
            check({v.name, "_data"}, 32'(got_data[i]), 32'(v.e_out[31-8*i -: 8]));
            check({v.name, "_last"}, 32'(got_last[i]), 32'(v.e_lastmask[i]));
        end
        check({v.name, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        tv[0] = '{"noise_hdr", 64'h5AB6023CC3000000, 5, 1'b1, 0, 1, 1, 0, 0, 2,
                  32'h3CC30000, 4'b0010, 1'b0, 8'h00};
        tv[1] = '{"overlap", 64'hB6D8000000000000, 2, 1'b1, 0, 1, 0, 1, 0, 0,
                  32'h0, 4'b0000, 1'b0, 8'h00};
        tv[2] = '{"len_zero", 64'hB600000000000000, 2, 1'b1, 0, 1, 1, 0, 0, 0,
                  32'h0, 4'b0000, 1'b0, 8'h00};
        tv[3] = '{"len_big", 64'hB611B601A5000000, 5, 1'b1, 0, 2, 1, 1, 0, 1,
                  32'hA5000000, 4'b0001, 1'b0, 8'h00};
        tv[4] = '{"backpres", 64'hB603112233000000, 5, 1'b0, 0, 1, 1, 0, 2, 1,
                  32'h11000000, 4'b0000, 1'b1, 8'h11};
        tv[5] = '{"gapped", 64'h5AB6023CC3000000, 5, 1'b1, 2, 1, 1, 0, 0, 2,
                  32'h3CC30000, 4'b0010, 1'b0, 8'h00};

        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("reset_state", 32'({out_data, out_valid, out_last, hdr_seen, len_err, overrun,
                                  pkt_done, busy}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(tv[i]);

        // Async reset while a byte is held mid-payload.
        clear_counts();
        send_byte(8'hB6, 1'b0, 0);
        send_byte(8'h02, 1'b0, 0);
        send_byte(8'hAA, 1'b0, 0);
        check("rst_pre_valid", 32'(out_valid), 32'd1);
        check("rst_pre_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst", 32'({out_data, out_valid, out_last, hdr_seen, len_err, overrun,
                                pkt_done, busy}), 32'd0);
        model_reset();
        #2 rst = 1'b0;
        clear_counts();
        send_byte(8'hB6, 1'b1, 0);
        send_byte(8'h01, 1'b1, 0);
        send_byte(8'h5C, 1'b1, 0);
        drain();
        check("post_rst_hdr", n_hdr, 1);
        check("post_rst_done", n_done, 1);
        check("post_rst_nout", got_data.size(), 1);
        if (got_data.size() > 0) begin
            check("post_rst_data", 32'(got_data[0]), 32'h5C);
            check("post_rst_last", 32'(got_last[0]), 32'd1);
        end

        // Random framed traffic with random gaps and backpressure.
        for (int p = 0; p < 60; p++) begin
            int         len;
            logic [7:0] b;
            len = int'($urandom_range(0, 20));
            for (int i = -2; i < len; i++) begin
                if (i == -2) b = 8'($urandom);
                else if (i == -1) b = HDR;
                else b = 8'($urandom);
                if (i == -1 && p % 3 != 0) begin
                    // Most packets carry a proper length byte right after the header.
                    for (int k = 7; k >= 0; k--) begin
                        while ($urandom_range(0, 3) == 0)
                            cycle(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6);
                        cycle(1'b1, b[k], $urandom_range(0, 9) < 6);
                    end
                    b = 8'(len);
                end
                for (int k = 7; k >= 0; k--) begin
                    while ($urandom_range(0, 3) == 0)
                        cycle(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6);
                    cycle(1'b1, b[k], $urandom_range(0, 9) < 6);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
